// File: rtl/ps2_keyboard_decoder.sv
// -----------------------------------------------------------------------------
// ps2_keyboard_decoder
//
// Receives PS/2 set-2 scan-code frames from a keyboard and keeps a Hack
// keycode of the key currently held, 0 when nothing is held.
//
// Ports
//   clk          system clock
//   reset_n      asynchronous active-low reset
//   ps2_clk      raw PS/2 clock from the pad (asynchronous to clk)
//   ps2_data     raw PS/2 data from the pad (asynchronous to clk)
//   keycode      registered Hack keycode of the held key, 0 when none
//   frame_error  one-cycle pulse when a frame is discarded (parity, stop
//                bit or inter-edge timeout)
//
// Parameter
//   TIMEOUT_CYCLES  maximum clk cycles between PS/2 falling edges inside
//                   one frame before the partial frame is abandoned (>= 2)
// -----------------------------------------------------------------------------
module ps2_keyboard_decoder #(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] keycode,
    output logic       frame_error
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    // Odd parity over data plus parity bit: the total number of ones is odd.
    function automatic logic parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

    // Set-2 scan code (with E0 extension flag) to Hack keycode; 0 = unmapped.
    function automatic logic [7:0] map_key(input logic ext, input logic [7:0] code);
        logic [7:0] k;
        k = 8'd0;
        case ({ext, code})
            // letters A..Z
            9'h01C: k = 8'd65;   9'h032: k = 8'd66;   9'h021: k = 8'd67;
            9'h023: k = 8'd68;   9'h024: k = 8'd69;   9'h02B: k = 8'd70;
            9'h034: k = 8'd71;   9'h033: k = 8'd72;   9'h043: k = 8'd73;
            9'h03B: k = 8'd74;   9'h042: k = 8'd75;   9'h04B: k = 8'd76;
            9'h03A: k = 8'd77;   9'h031: k = 8'd78;   9'h044: k = 8'd79;
            9'h04D: k = 8'd80;   9'h015: k = 8'd81;   9'h02D: k = 8'd82;
            9'h01B: k = 8'd83;   9'h02C: k = 8'd84;   9'h03C: k = 8'd85;
            9'h02A: k = 8'd86;   9'h01D: k = 8'd87;   9'h022: k = 8'd88;
            9'h035: k = 8'd89;   9'h01A: k = 8'd90;
            // digits 0..9
            9'h045: k = 8'd48;   9'h016: k = 8'd49;   9'h01E: k = 8'd50;
            9'h026: k = 8'd51;   9'h025: k = 8'd52;   9'h02E: k = 8'd53;
            9'h036: k = 8'd54;   9'h03D: k = 8'd55;   9'h03E: k = 8'd56;
            9'h046: k = 8'd57;
            // space, enter, backspace, escape
            9'h029: k = 8'd32;   9'h05A: k = 8'd128;  9'h066: k = 8'd129;
            9'h076: k = 8'd140;
            // extended navigation keys
            9'h16B: k = 8'd130;  9'h175: k = 8'd131;  9'h174: k = 8'd132;
            9'h172: k = 8'd133;  9'h16C: k = 8'd134;  9'h169: k = 8'd135;
            9'h17D: k = 8'd136;  9'h17A: k = 8'd137;  9'h170: k = 8'd138;
            9'h171: k = 8'd139;
            // F1..F12
            9'h005: k = 8'd141;  9'h006: k = 8'd142;  9'h004: k = 8'd143;
            9'h00C: k = 8'd144;  9'h003: k = 8'd145;  9'h00B: k = 8'd146;
            9'h083: k = 8'd147;  9'h00A: k = 8'd148;  9'h001: k = 8'd149;
            9'h009: k = 8'd150;  9'h078: k = 8'd151;  9'h007: k = 8'd152;
            default: k = 8'd0;
        endcase
        return k;
    endfunction

    logic            ps2_clk_meta_r;
    logic            ps2_clk_sync_r;
    logic            ps2_clk_prev_r;
    logic            ps2_data_meta_r;
    logic            ps2_data_sync_r;
    logic            fall_s;
    logic            data_s;

    state_t          state_r;
    logic [3:0]      bit_cnt_r;
    logic [7:0]      shift_r;
    logic            parity_r;
    logic [TO_W-1:0] timeout_r;
    logic            byte_valid_r;
    logic            timeout_hit_r;
    logic            frame_error_r;

    logic            ext_r;
    logic            brk_r;
    logic [7:0]      keycode_r;
    logic [7:0]      map_s;

    // Two-flop synchronizers plus the previous-clock flop for edge detection.
    // All idle high so that reset release never looks like a falling edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ps2_clk_meta_r  <= 1'b1;
            ps2_clk_sync_r  <= 1'b1;
            ps2_clk_prev_r  <= 1'b1;
            ps2_data_meta_r <= 1'b1;
            ps2_data_sync_r <= 1'b1;
        end else begin
            ps2_clk_meta_r  <= ps2_clk;
            ps2_clk_sync_r  <= ps2_clk_meta_r;
            ps2_clk_prev_r  <= ps2_clk_sync_r;
            ps2_data_meta_r <= ps2_data;
            ps2_data_sync_r <= ps2_data_meta_r;
        end
    end

    // Falling edge of the synchronized PS/2 clock; data is sampled alongside.
    always_comb begin
        fall_s = ps2_clk_prev_r & ~ps2_clk_sync_r;
        data_s = ps2_data_sync_r;
    end

    // Frame receiver: start bit, 8 data bits LSB first, parity, stop.
    // bit_cnt_r counts bits after the start bit: 0..7 data, 8 parity, 9 stop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= IDLE;
            bit_cnt_r     <= 4'd0;
            shift_r       <= 8'd0;
            parity_r      <= 1'b0;
            timeout_r     <= '0;
            byte_valid_r  <= 1'b0;
            timeout_hit_r <= 1'b0;
            frame_error_r <= 1'b0;
        end else begin
            byte_valid_r  <= 1'b0;
            timeout_hit_r <= 1'b0;
            frame_error_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    bit_cnt_r <= 4'd0;
                    timeout_r <= '0;
                    if (fall_s && !data_s) begin
                        state_r <= RECV;
                    end
                end
                RECV: begin
                    if (fall_s) begin
                        timeout_r <= '0;
                        bit_cnt_r <= bit_cnt_r + 4'd1;
                        if (bit_cnt_r < 4'd8) begin
                            shift_r <= {data_s, shift_r[7:1]};
                        end else if (bit_cnt_r == 4'd8) begin
                            parity_r <= data_s;
                        end else begin
                            // Stop bit: shift_r is held until the next frame's
                            // first data bit, so the decoder reads it directly.
                            state_r   <= IDLE;
                            bit_cnt_r <= 4'd0;
                            if (parity_ok(shift_r, parity_r) && data_s) begin
                                byte_valid_r <= 1'b1;
                            end else begin
                                frame_error_r <= 1'b1;
                            end
                        end
                    end else if (timeout_r == TO_LAST) begin
                        state_r       <= IDLE;
                        bit_cnt_r     <= 4'd0;
                        timeout_r     <= '0;
                        timeout_hit_r <= 1'b1;
                        frame_error_r <= 1'b1;
                    end else begin
                        timeout_r <= timeout_r + TO_W'(1);
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Combinational lookup of the received code byte.
    always_comb begin
        map_s = map_key(ext_r, shift_r);
    end

    // Prefix tracking and keycode update, one cycle after a byte is accepted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ext_r     <= 1'b0;
            brk_r     <= 1'b0;
            keycode_r <= 8'd0;
        end else begin
            if (byte_valid_r) begin
                if (shift_r == 8'hE0) begin
                    ext_r <= 1'b1;
                end else if (shift_r == 8'hF0) begin
                    brk_r <= 1'b1;
                end else begin
                    ext_r <= 1'b0;
                    brk_r <= 1'b0;
                    if (!brk_r) begin
                        // Make: last-pressed key wins, repeats rewrite it.
                        if (map_s != 8'd0) begin
                            keycode_r <= map_s;
                        end
                    end else if ((map_s != 8'd0) && (map_s == keycode_r)) begin
                        // Break only releases the key that is shown.
                        keycode_r <= 8'd0;
                    end
                end
            end else if (timeout_hit_r) begin
                ext_r <= 1'b0;
                brk_r <= 1'b0;
            end
        end
    end

    assign keycode     = keycode_r;
    assign frame_error = frame_error_r;

endmodule
